// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding memory fetch FSM feeding a prefetch FIFO of {pc, instr}.
// Define IFU_STAT_EN to add the stat_fetch / stat_discard counters.
module instr_fetch_unit #(
  parameter int unsigned           ADDR_LEN  = 32,
  parameter int unsigned           INSTR_LEN = 32,
  parameter int unsigned           DEPTH     = 4,
  parameter logic [ADDR_LEN-1:0]   RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 redirect,
  input  logic [ADDR_LEN-1:0]  redirect_pc,
  output logic                 mem_req,
  output logic [ADDR_LEN-1:0]  mem_addr,
  input  logic                 mem_ack,
  input  logic [INSTR_LEN-1:0] mem_rdata,
  output logic                 instr_valid,
  output logic [INSTR_LEN-1:0] instr,
  output logic [ADDR_LEN-1:0]  instr_pc,
  input  logic                 instr_ready
`ifdef IFU_STAT_EN
  ,
  output logic [31:0]          stat_fetch,
  output logic [31:0]          stat_discard
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t               state, state_next;
  logic [ADDR_LEN-1:0]  fetch_pc, fetch_pc_next, target;
  logic [PW-1:0]        rd_ptr, wr_ptr, rd_ptr_next, wr_ptr_next;
  logic [CW-1:0]        count, count_pop, count_next;
  logic                 push, pop, discard;
  logic [ADDR_LEN-1:0]  head_pc_next;
  logic [INSTR_LEN-1:0] head_instr_next;

  logic [ADDR_LEN-1:0]  pc_mem    [DEPTH];
  logic [INSTR_LEN-1:0] instr_mem [DEPTH];

  always_comb begin
    pop        = instr_valid && instr_ready && !redirect;
    push       = (state == REQ) && mem_ack && !redirect;
    discard    = mem_ack && (((state == REQ) && redirect) || (state == DRAIN));
    target     = redirect_pc & ~ADDR_LEN'(3);
    count_pop  = count - CW'(pop);
    count_next = redirect ? '0 : count_pop + CW'(push);
    rd_ptr_next = redirect ? '0 : rd_ptr + PW'(pop);
    wr_ptr_next = redirect ? '0 : wr_ptr + PW'(push);
    fetch_pc_next = redirect ? target : (push ? fetch_pc + ADDR_LEN'(4) : fetch_pc);

    // A request is only issued when a slot is free after this edge, so an ack can always push.
    state_next = state;
    unique case (state)
      IDLE:    if (count_next < CW'(DEPTH)) state_next = REQ;
      REQ: begin
        if (redirect)                                    state_next = mem_ack ? REQ : DRAIN;
        else if (mem_ack && (count_next >= CW'(DEPTH))) state_next = IDLE;
      end
      DRAIN:   if (mem_ack) state_next = REQ;
      default: state_next = IDLE;
    endcase

    // Head registers track the entry at the read pointer after this edge, bypassing a push into an empty queue.
    head_pc_next    = instr_pc;
    head_instr_next = instr;
    if (push && (count_pop == '0)) begin
      head_pc_next    = fetch_pc;
      head_instr_next = mem_rdata;
    end else if (count_next != '0) begin
      head_pc_next    = pc_mem[rd_ptr_next];
      head_instr_next = instr_mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      state       <= state_next;
      fetch_pc    <= fetch_pc_next;
      rd_ptr      <= rd_ptr_next;
      wr_ptr      <= wr_ptr_next;
      count       <= count_next;
      mem_req     <= (state_next != IDLE);
      // DRAIN keeps presenting the orphaned address until its ack.
      if (state_next == REQ) mem_addr <= fetch_pc_next;
      instr_valid <= (count_next != '0);
      instr       <= head_instr_next;
      instr_pc    <= head_pc_next;
    end
  end

`ifdef IFU_STAT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_fetch   <= '0;
      stat_discard <= '0;
    end else begin
      if (push)    stat_fetch   <= stat_fetch + 32'd1;
      if (discard) stat_discard <= stat_discard + 32'd1;
    end
  end
`endif

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter: ADDR_LEN, 32, byte-address and PC width.
REQ-002 Parameter: INSTR_LEN, 32, instruction width.
REQ-003 Parameter: DEPTH, 4, prefetch queue entries; power of two, minimum 2.
REQ-004 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 redirect  in  1  flush the queue and restart fetch at redirect_pc (branch/jump taken).
REQ-008 redirect_pc  in  ADDR_LEN  new fetch address; bits [1:0] ignored, treated as 0.
REQ-009 mem_req  out  1  instruction memory request.
REQ-010 mem_addr  out  ADDR_LEN  request address, word-aligned.
REQ-011 mem_ack  in  1  memory completes the current request this cycle.
REQ-012 mem_rdata  in  INSTR_LEN  instruction word, valid when mem_ack=1.
REQ-013 instr_valid  out  1  queue head holds a valid instruction.
REQ-014 instr  out  INSTR_LEN  queue head instruction.
REQ-015 instr_pc  out  ADDR_LEN  address of the queue head instruction.
REQ-016 instr_ready  in  1  consumer accepts the head this cycle.

Function
REQ-017 The FIFO holds {pc, instr} pairs. instr_valid = not empty. The head is popped on the edge where instr_valid&&instr_ready; outputs are driven from registers only.
REQ-018 The FSM has three states. IDLE: mem_req=0. REQ: mem_req=1 and waiting for ack. DRAIN: mem_req=1, waiting for the ack of a request orphaned by a redirect.
REQ-019 IDLE->REQ when occupancy after this edge's pop is < DEPTH; a slot is reserved so a returning ack never overflows.
REQ-020 In REQ, mem_addr = fetch_pc, held stable until mem_ack. Only one request is outstanding at a time.
REQ-021 REQ with mem_ack:
- pushes {fetch_pc, mem_rdata} and sets fetch_pc += 4;
- stays in REQ if space remains, else goes to IDLE;
- with mem_ack held high, throughput is one instruction per cycle.
REQ-022 Pushed data is visible at instr/instr_valid the cycle after the ack edge (1-cycle latency).
REQ-023 Push and pop on the same edge leave occupancy unchanged. A pop on the full edge frees the reserved slot on that same edge.
REQ-024 fetch_pc wraps modulo 2^ADDR_LEN: after 32'hFFFF_FFFC the next fetch is 32'h0000_0000.
REQ-025 redirect=1 effects on the same edge:
- queue emptied;
- fetch_pc = {redirect_pc[31:2], 2'b00};
- redirect has priority over any same-cycle push or pop.
REQ-026 redirect while in REQ without mem_ack -> DRAIN. mem_addr stays at the old address until ack, then the ack data is discarded and the FSM enters REQ at the new fetch_pc.
REQ-027 redirect with a same-cycle mem_ack: the ack data is discarded and the FSM enters REQ at the new fetch_pc, without DRAIN.
REQ-028 redirect while in DRAIN: fetch_pc is updated to the latest target and the FSM stays in DRAIN.
REQ-029 instr_valid is 0 on the cycle after any redirect edge.

Reset
REQ-030 rst low asynchronously forces:
- FSM=IDLE, queue empty, fetch_pc=RESET_PC;
- mem_req=0, instr_valid=0, instr=0, instr_pc=0.
REQ-031 On the first rising edge after rst deasserts, the FSM goes IDLE->REQ with mem_addr=RESET_PC.
REQ-032 Reset mid-request abandons the outstanding request. An ack arriving after reset while mem_req=0 is ignored.

Configuration
REQ-033 Macro IFU_STAT_EN defined: adds outputs stat_fetch (32-bit, counts accepted pushes) and stat_discard (32-bit, counts acks discarded by redirect/DRAIN). Both counters wrap, are cleared by reset, and do not saturate.
REQ-034 IFU_STAT_EN undefined: these ports and counters are absent; all other behaviour is identical.

Verification
REQ-035 Reset release, mem_ack tied 1, instr_ready=1, mem_rdata=addr -> mem_addr 0,4,8,…; instr_pc==instr each cycle; instr_valid first high at cycle 2 after release.
REQ-036 instr_ready=0, ack always 1, DEPTH=4 -> exactly 4 pushes then mem_req=0. Raising instr_ready restores 1/cycle with no lost or duplicated PC.
REQ-037 Ack delayed 3 cycles, redirect to 32'h0000_0102 in cycle 1 of wait:
- old mem_addr held until ack, that data dropped;
- next mem_addr=32'h0000_0100;
- first instr_pc=32'h0000_0100.
REQ-038 redirect and mem_ack in the same cycle with full queue and instr_ready=1 -> queue empty next cycle, no old-stream instruction ever appears, fetch restarts at the target.
REQ-039 Redirect to 32'hFFFF_FFF8 with ack=1 -> fetch sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-040 rst asserted mid-REQ, then released -> all outputs at reset values while low, then fetch at RESET_PC. With IFU_STAT_EN, stat counters read 0 after reset and stat_discard increments once in REQ-037.
